uart_cmd_led_ctrl: RTL and testbench
====================================

UART_CMD_LED_CTRL -- requirements
Module: uart_cmd_led_ctrl

Interface
REQ-001 SHALL have parameter LED_W, default 8 (legal 1..16), the width of the LED register.
REQ-002 SHALL have parameter BUF_DEPTH, default 16 (legal 2..32), the command buffer depth in bytes.
REQ-003 SHALL have parameter ECHO_EN, default 1, which enables echo of accepted characters.
REQ-004 SHALL provide clk, input, 1 bit, rising-edge system clock.
REQ-005 SHALL provide rst, input, 1 bit, reset; asynchronous, active-high.
REQ-006 SHALL provide rx_data, input, 8 bits, received byte, valid only when rx_valid=1.
REQ-007 SHALL provide rx_valid, input, 1 bit, single-cycle strobe for each received byte; no back-pressure.
REQ-008 SHALL provide tx_data, output, 8 bits, byte presented to the transmitter.
REQ-009 SHALL provide tx_valid, output, 1 bit, tx_data valid; held until accepted.
REQ-010 SHALL provide tx_ready, input, 1 bit; a transfer occurs on a cycle with tx_valid=1 and tx_ready=1.
REQ-011 SHALL provide led, output, LED_W bits, registered LED state.
REQ-012 SHALL provide cmd_err, output, 1 bit, one-cycle pulse when a command is rejected.
REQ-013 SHALL provide rx_drop, output, 1 bit, one-cycle pulse when a received byte is discarded.

Function
REQ-014 SHALL implement exactly four states: COLLECT, EXEC, RESP, and DRAIN; the reset state is COLLECT.
REQ-015 In COLLECT, SHALL handle a byte of 0x0D (CR) by moving to EXEC on the next cycle.
REQ-016 In COLLECT, SHALL ignore a byte of 0x0A (LF) without buffering it, echoing it, or pulsing rx_drop.
REQ-017 In COLLECT, SHALL handle 0x08 (backspace) by decrementing the count when count>0 and echoing 0x08 when ECHO_EN=1; when count=0 the byte is ignored.
REQ-018 In COLLECT, SHALL store any other byte at buf[count] and increment count when count<BUF_DEPTH.
REQ-019 When count=BUF_DEPTH, SHALL not store the byte, SHALL set the sticky ovf flag, and SHALL pulse rx_drop.
REQ-020 When ECHO_EN=1 and tx_valid=0, SHALL echo each stored byte by driving tx_data=byte and tx_valid=1 on the next cycle.
REQ-021 If tx_valid=1 when a byte is stored, SHALL skip the echo but still store the byte.
REQ-022 SHALL decode commands in EXEC, in one cycle, from buf[0..count-1] where count is the final length; digit d is an uppercase hex digit 0-9 or A-F.
  - "1" (count=1): led set to all ones.
  - "0" (count=1): led set to all zeros.
  - "Td" (count=2): led[d] toggled.
  - "Sd" (count=2): led[d] set.
  - "Cd" (count=2): led[d] cleared.
  - "?" (count=1): led unchanged; value reported.
REQ-023 SHALL reject the command (ER) when ovf=1, count=0, the opcode is unknown, the length is wrong, d is not hex, or d>=LED_W.
REQ-024 On rejection, SHALL leave led unchanged and pulse cmd_err in the EXEC cycle.
REQ-025 SHALL update led at the clock edge ending EXEC, so the new value is visible 2 cycles after the CR strobe.
REQ-026 SHALL go from EXEC to DRAIN if tx_valid=1, otherwise to RESP.
REQ-027 SHALL stay in DRAIN until the pending byte transfers, then go to RESP.
REQ-028 In RESP, SHALL send a response sequence:
  - accepted command: "OK\r\n", i.e. 0x4F 0x4B 0x0D 0x0A;
  - rejected command: "ER\r\n";
  - "?": ceil(LED_W/4) uppercase hex digits, MSB nibble first, then "\r\n".
REQ-029 SHALL send response bytes back-to-back, with the next byte presented in the cycle after each transfer; tx_data SHALL stay stable while tx_valid=1 and tx_ready=0.
REQ-030 After the final response byte transfers, SHALL clear count and ovf and return to COLLECT on the next cycle.
REQ-031 Any rx_valid byte arriving in EXEC, DRAIN, or RESP SHALL be discarded with an rx_drop pulse.
REQ-032 Any rx_valid byte arriving in the cycle of the COLLECT-to-EXEC transition SHALL be treated as arriving in EXEC.
REQ-033 For the "?" report, SHALL snapshot the LED value at EXEC and zero-extend it to whole nibbles.

Reset
REQ-034 While rst=1, SHALL force state=COLLECT, count=0, ovf=0, led=0, tx_valid=0, tx_data=0x00, cmd_err=0, and rx_drop=0.
REQ-035 An rst assertion during RESP SHALL abort the response immediately, with no further tx_valid until a new command completes.

Verification
REQ-036 SHALL cover: defaults, tx_ready=1, send "1",CR -> echo 0x31; led=0xFF two cycles after CR; then "OK\r\n".
REQ-037 SHALL cover: led=0xFF, send "T3",CR -> led=0xF7 and "OK\r\n"; then "?",CR -> "F7\r\n".
REQ-038 SHALL cover: LED_W=8, send "S9",CR -> led unchanged, one cmd_err pulse, "ER\r\n".
REQ-039 SHALL cover: 17 non-CR bytes then CR with BUF_DEPTH=16 -> one rx_drop pulse on byte 17, ER response, count=0 afterwards.
REQ-040 SHALL cover: tx_ready held 0 for 50 cycles during RESP -> tx_data stable, a byte sent during RESP dropped with an rx_drop pulse, and the response completes correctly once tx_ready=1.
REQ-041 SHALL cover: rst asserted mid-"OK" response -> tx_valid=0 and led=0 at once; a following "0",CR gives "OK\r\n".

Source files
------------

// File: rtl/uart_cmd_led_ctrl.sv
// UART command interpreter: buffers a line of text, decodes LED commands on CR,
// and sends "OK", "ER" or a hex LED report back through the transmit handshake.
module uart_cmd_led_ctrl #(
  parameter int unsigned LED_W     = 8,
  parameter int unsigned BUF_DEPTH = 16,
  parameter bit          ECHO_EN   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [LED_W-1:0] led,
  output logic             cmd_err,
  output logic             rx_drop
);

  localparam int unsigned CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int unsigned AW     = $clog2(BUF_DEPTH);
  localparam int unsigned NIB    = (LED_W + 3) / 4;
  localparam int unsigned SNAP_W = NIB * 4;
  localparam int unsigned IDX_W  = 3;

  localparam logic [CNT_W-1:0] FULL   = CNT_W'(BUF_DEPTH);
  localparam logic [4:0]       LED_W5 = 5'(LED_W);
  localparam logic [7:0]       CH_CR  = 8'h0D;
  localparam logic [7:0]       CH_LF  = 8'h0A;
  localparam logic [7:0]       CH_BS  = 8'h08;

  typedef enum logic [1:0] {COLLECT, EXEC, RESP, DRAIN} state_t;
  typedef enum logic [1:0] {R_OK, R_ER, R_QRY} resp_t;

  state_t             state, state_n;
  resp_t              kind, kind_n, kind_c;
  logic [CNT_W-1:0]   count, count_n;
  logic               ovf, ovf_n;
  logic [LED_W-1:0]   led_n, led_new_c, mask_c;
  logic [SNAP_W-1:0]  snap, snap_n;
  logic [IDX_W-1:0]   idx, idx_n, last_c;
  logic [7:0]         tx_data_n;
  logic               tx_valid_n, cmd_err_n, rx_drop_n;
  logic               buf_we, reject_c, dhex_c;
  logic [4:0]         dval_c;
  logic [7:0]         op_c, dch_c;
  logic [7:0]         cmd_buf [BUF_DEPTH];

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
  endfunction

  function automatic logic [7:0] resp_byte(input resp_t k, input logic [IDX_W-1:0] i,
                                           input logic [SNAP_W-1:0] s);
    logic [3:0] nib;
    logic [7:0] b;
    nib = 4'(s >> (4 * (NIB - 1 - 32'(i))));
    b   = CH_LF;
    if (k == R_QRY) begin
      if (32'(i) < NIB)       b = hex_char(nib);
      else if (32'(i) == NIB) b = CH_CR;
    end else begin
      case (i)
        3'd0:    b = (k == R_OK) ? 8'h4F : 8'h45;
        3'd1:    b = (k == R_OK) ? 8'h4B : 8'h52;
        3'd2:    b = CH_CR;
        default: b = CH_LF;
      endcase
    end
    return b;
  endfunction

  // Command decode from the buffered line; stable from the CR cycle through EXEC
  always_comb begin
    op_c      = cmd_buf[0];
    dch_c     = cmd_buf[1];
    dhex_c    = 1'b0;
    dval_c    = 5'd0;
    reject_c  = 1'b1;
    kind_c    = R_ER;
    led_new_c = led;
    if (dch_c >= 8'h30 && dch_c <= 8'h39) begin
      dhex_c = 1'b1;
      dval_c = 5'(dch_c - 8'h30);
    end else if (dch_c >= 8'h41 && dch_c <= 8'h46) begin
      dhex_c = 1'b1;
      dval_c = 5'(dch_c - 8'h37);
    end
    mask_c = LED_W'(1) << dval_c;
    if (!ovf && count == CNT_W'(1)) begin
      case (op_c)
        8'h31: begin reject_c = 1'b0; kind_c = R_OK;  led_new_c = '1; end
        8'h30: begin reject_c = 1'b0; kind_c = R_OK;  led_new_c = '0; end
        8'h3F: begin reject_c = 1'b0; kind_c = R_QRY; end
        default: ;
      endcase
    end else if (!ovf && count == CNT_W'(2) && dhex_c && dval_c < LED_W5) begin
      case (op_c)
        8'h54: begin reject_c = 1'b0; kind_c = R_OK; led_new_c = led ^ mask_c;  end
        8'h53: begin reject_c = 1'b0; kind_c = R_OK; led_new_c = led | mask_c;  end
        8'h43: begin reject_c = 1'b0; kind_c = R_OK; led_new_c = led & ~mask_c; end
        default: ;
      endcase
    end
  end

  assign last_c = (kind == R_QRY) ? IDX_W'(NIB + 1) : IDX_W'(3);

  // Next-state and next-output logic
  always_comb begin
    state_n    = state;
    kind_n     = kind;
    count_n    = count;
    ovf_n      = ovf;
    led_n      = led;
    snap_n     = snap;
    idx_n      = idx;
    tx_data_n  = tx_data;
    tx_valid_n = tx_valid;
    cmd_err_n  = 1'b0;
    rx_drop_n  = 1'b0;
    buf_we     = 1'b0;
    if (tx_valid && tx_ready) tx_valid_n = 1'b0;
    case (state)
      COLLECT: begin
        if (rx_valid) begin
          if (rx_data == CH_CR) begin
            state_n   = EXEC;
            cmd_err_n = reject_c;
          end else if (rx_data == CH_LF) begin
            state_n = COLLECT;
          end else if (rx_data == CH_BS) begin
            if (count != '0) begin
              count_n = count - CNT_W'(1);
              if (ECHO_EN && !tx_valid) begin
                tx_data_n  = CH_BS;
                tx_valid_n = 1'b1;
              end
            end
          end else if (count < FULL) begin
            buf_we  = 1'b1;
            count_n = count + CNT_W'(1);
            if (ECHO_EN && !tx_valid) begin
              tx_data_n  = rx_data;
              tx_valid_n = 1'b1;
            end
          end else begin
            ovf_n     = 1'b1;
            rx_drop_n = 1'b1;
          end
        end
      end
      EXEC: begin
        rx_drop_n = rx_valid;
        led_n     = led_new_c;
        kind_n    = kind_c;
        snap_n    = SNAP_W'(led);
        idx_n     = '0;
        state_n   = tx_valid ? DRAIN : RESP;
      end
      DRAIN: begin
        rx_drop_n = rx_valid;
        if (!tx_valid || tx_ready) state_n = RESP;
      end
      RESP: begin
        rx_drop_n = rx_valid;
        if (!tx_valid) begin
          tx_data_n  = resp_byte(kind, idx, snap);
          tx_valid_n = 1'b1;
        end else if (tx_ready) begin
          if (idx == last_c) begin
            tx_valid_n = 1'b0;
            count_n    = '0;
            ovf_n      = 1'b0;
            state_n    = COLLECT;
          end else begin
            idx_n      = idx + IDX_W'(1);
            tx_data_n  = resp_byte(kind, idx + IDX_W'(1), snap);
            tx_valid_n = 1'b1;
          end
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= COLLECT;
      kind     <= R_OK;
      count    <= '0;
      ovf      <= 1'b0;
      led      <= '0;
      snap     <= '0;
      idx      <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      cmd_err  <= 1'b0;
      rx_drop  <= 1'b0;
    end else begin
      state    <= state_n;
      kind     <= kind_n;
      count    <= count_n;
      ovf      <= ovf_n;
      led      <= led_n;
      snap     <= snap_n;
      idx      <= idx_n;
      tx_data  <= tx_data_n;
      tx_valid <= tx_valid_n;
      cmd_err  <= cmd_err_n;
      rx_drop  <= rx_drop_n;
    end
  end

  // Command line storage
  always_ff @(posedge clk) begin
    if (buf_we) cmd_buf[AW'(count)] <= rx_data;
  end

endmodule

// File: tb/tb_uart_cmd_led_ctrl.sv
// Scoreboard bench for uart_cmd_led_ctrl: expected tx bytes are queued by the
// stimulus, and a negedge monitor pops and compares on every transfer.
module tb_uart_cmd_led_ctrl;

  localparam int unsigned LED_W = 8;

  logic             clk, rst;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [LED_W-1:0] led;
  logic             cmd_err;
  logic             rx_drop;

  int vectors = 0;
  int errors  = 0;
  int err_seen = 0;
  int drop_seen = 0;
  logic [7:0] exp_q[$];
  logic       hold_pending = 1'b0;
  logic [7:0] hold_data = 8'h00;

  uart_cmd_led_ctrl #(.LED_W(LED_W), .BUF_DEPTH(16), .ECHO_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .led(led), .cmd_err(cmd_err), .rx_drop(rx_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: transfers against the scoreboard, hold stability, pulse counting
  always @(negedge clk) begin
    if (rst) begin
      hold_pending <= 1'b0;
    end else begin
      if (cmd_err) err_seen++;
      if (rx_drop) drop_seen++;
      if (tx_valid && hold_pending) begin
        vectors++;
        if (tx_data !== hold_data) begin
          errors++;
          $display("FAIL tx_hold_stable got %h want %h", tx_data, hold_data);
        end
      end
      if (tx_valid && tx_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected got %h want none", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            errors++;
            $display("FAIL tx_byte got %h want %h", tx_data, e);
          end
        end
        hold_pending <= 1'b0;
      end else if (tx_valid) begin
        hold_pending <= 1'b1;
        hold_data    <= tx_data;
      end else begin
        hold_pending <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit echo);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    if (echo) exp_q.push_back(b);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // CR plus led timing: old value one cycle after CR, new value two cycles after
  task automatic send_cr(input string nm, input logic [LED_W-1:0] old_led,
                         input logic [LED_W-1:0] new_led, input string resp);
    @(posedge clk); #1;
    rx_data  = 8'h0D;
    rx_valid = 1'b1;
    for (int i = 0; i < resp.len(); i++) exp_q.push_back(8'(resp[i]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_led_exec"}, 32'(led), 32'(old_led));
    @(negedge clk);
    chk({nm, "_led"}, 32'(led), 32'(new_led));
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drain_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_pulses(input string nm, input int e0, input int d0,
                            input int de, input int dd);
    chk({nm, "_cmd_err"}, 32'(err_seen - e0), 32'(de));
    chk({nm, "_rx_drop"}, 32'(drop_seen - d0), 32'(dd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1);
  end

  initial begin
    int e0, d0, n;
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_led", 32'(led), 32'h00);
    chk("rst_cmd_err", 32'(cmd_err), 32'd0);
    chk("rst_rx_drop", 32'(rx_drop), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // "1" -> all ones
    e0 = err_seen; d0 = drop_seen;
    send_byte(8'h31, 1'b1);
    send_cr("all_on", 8'h00, 8'hFF, "OK");
    wait_drain("all_on");
    chk_pulses("all_on", e0, d0, 0, 0);

    // "T3" toggles bit 3, then "?" reports F7
    send_byte(8'h54, 1'b1); send_byte(8'h33, 1'b1);
    send_cr("toggle3", 8'hFF, 8'hF7, "OK");
    wait_drain("toggle3");
    send_byte(8'h3F, 1'b1);
    send_cr("query", 8'hF7, 8'hF7, "F7");
    wait_drain("query");

    // "S9" out of range for 8 LEDs
    e0 = err_seen; d0 = drop_seen;
    send_byte(8'h53, 1'b1); send_byte(8'h39, 1'b1);
    send_cr("set9", 8'hF7, 8'hF7, "ER");
    wait_drain("set9");
    chk_pulses("set9", e0, d0, 1, 0);

    // 17 bytes overflow a 16-byte buffer
    e0 = err_seen; d0 = drop_seen;
    for (int i = 0; i < 17; i++) send_byte(8'h41, i < 16);
    send_cr("ovf", 8'hF7, 8'hF7, "ER");
    wait_drain("ovf");
    chk_pulses("ovf", e0, d0, 1, 1);

    // buffer and overflow flag cleared: "C0" must be accepted
    send_byte(8'h43, 1'b1); send_byte(8'h30, 1'b1);
    send_cr("clr0", 8'hF7, 8'hF6, "OK");
    wait_drain("clr0");

    // backspace at empty line is ignored; backspace after X removes it
    e0 = err_seen; d0 = drop_seen;
    send_byte(8'h08, 1'b0);
    send_byte(8'h58, 1'b1); send_byte(8'h08, 1'b1); send_byte(8'h30, 1'b1);
    send_cr("bs_zero", 8'hF6, 8'h00, "OK");
    wait_drain("bs_zero");
    chk_pulses("bs_zero", e0, d0, 0, 0);

    // unknown opcode, non-hex digit
    send_byte(8'h5A, 1'b1);
    send_cr("unk", 8'h00, 8'h00, "ER");
    wait_drain("unk");
    send_byte(8'h53, 1'b1); send_byte(8'h47, 1'b1);
    send_cr("nonhex", 8'h00, 8'h00, "ER");
    wait_drain("nonhex");

    // empty line rejected
    e0 = err_seen; d0 = drop_seen;
    send_cr("empty", 8'h00, 8'h00, "ER");
    wait_drain("empty");
    chk_pulses("empty", e0, d0, 1, 0);

    // LF ignored inside a line
    e0 = err_seen; d0 = drop_seen;
    send_byte(8'h31, 1'b1); send_byte(8'h0A, 1'b0);
    send_cr("lf", 8'h00, 8'hFF, "OK");
    wait_drain("lf");
    chk_pulses("lf", e0, d0, 0, 0);

    // back-pressure during response, with a byte dropped meanwhile
    e0 = err_seen; d0 = drop_seen;
    send_byte(8'h43, 1'b1); send_byte(8'h37, 1'b1);
    @(posedge clk); #1 tx_ready = 1'b0;
    send_cr("stall", 8'hFF, 8'h7F, "OK");
    send_byte(8'h58, 1'b0);
    repeat (46) @(posedge clk);
    #1 tx_ready = 1'b1;
    wait_drain("stall");
    chk_pulses("stall", e0, d0, 0, 1);

    // reset in the middle of the OK response
    send_byte(8'h31, 1'b1);
    send_cr("rst_mid", 8'h7F, 8'hFF, "OK");
    n = 0;
    while (exp_q.size() > 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_progress", 32'(exp_q.size() <= 2), 32'd1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_mid_led", 32'(led), 32'h00);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    send_byte(8'h30, 1'b1);
    send_cr("after_rst", 8'h00, 8'h00, "OK");
    wait_drain("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
